vip_matrix_generate_3x3: RTL and testbench

VIP_MATRIX_GENERATE_3X3 -- requirements
Module: vip_matrix_generate_3x3

---
 rtl/vip_pkg.sv | 24 ++
 rtl/vip_line_buffer.sv | 23 ++
 rtl/vip_matrix_generate_3x3.sv | 154 +++++++++++++++
 tb/tb_vip_matrix_generate_3x3.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_pkg.sv
// Shared types and default geometry for the VIP pixel pipeline.
package vip_pkg;

  localparam int unsigned VIP_IMG_HDISP = 640;
  localparam int unsigned VIP_IMG_VDISP = 480;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } vip_state_e;

  // One vertical slice of the 3x3 window: rows r-1, r, r+1 of a single column.
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } vip_col_t;

endpackage

// File: rtl/vip_line_buffer.sv
// Single-line pixel store: independent write/read ports, registered read,
// read-before-write when both ports hit the same address.
module vip_line_buffer #(
  parameter  int unsigned DEPTH = vip_pkg::VIP_IMG_HDISP,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vip_matrix_generate_3x3.sv
// 3x3 neighbourhood generator for the Y plane with an internally flushed last line.
// Build option: VIP_MATRIX_ZERO_PAD_EN selects zero padding instead of edge replication.
module vip_matrix_generate_3x3
  import vip_pkg::*;
#(
  parameter int unsigned IMG_HDISP = VIP_IMG_HDISP,
  parameter int unsigned IMG_VDISP = VIP_IMG_VDISP,
  parameter int unsigned FLUSH_GAP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       matrix_img_vsync,
  output logic       matrix_img_href,
  output logic [7:0] matrix_p11, matrix_p12, matrix_p13,
  output logic [7:0] matrix_p21, matrix_p22, matrix_p23,
  output logic [7:0] matrix_p31, matrix_p32, matrix_p33
);

  localparam int unsigned AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned RW = $clog2(IMG_VDISP + 1);
  localparam logic [AW-1:0] LAST_COL    = AW'(IMG_HDISP - 1);
  localparam logic [RW-1:0] ROWS        = RW'(IMG_VDISP);
  localparam logic [RW-1:0] LAST_ROW    = RW'(IMG_VDISP - 1);
  localparam logic [15:0]   FLUSH_START = 16'(FLUSH_GAP - 2);
  localparam vip_col_t      ZERO_COL    = '0;
`ifdef VIP_MATRIX_ZERO_PAD_EN
  localparam logic ZERO_PAD = 1'b1;
`else
  localparam logic ZERO_PAD = 1'b0;
`endif

  vip_state_e    state, state_nxt;
  logic          vsync_d, href_acc, href_acc_d, eol;
  logic          fl_href, fl_done, line_on, v_d, vs_set, vs_clr;
  logic [AW-1:0] col, oc, rd_addr;
  logic [RW-1:0] in_row;
  logic [15:0]   gap_cnt;
  logic [1:0]    done_cnt;
  pixel_t        lb1_q, lb2_q;
  vip_col_t      cur_col, col_d, col_dd, win_l, win_r;

  assign href_acc = per_img_href & per_img_vsync & (in_row < ROWS) &
                    ((state == ST_FILL) | (state == ST_STREAM));
  assign eol      = href_acc_d & ~href_acc;
  assign fl_href  = (state == ST_FLUSH) & ~fl_done & (gap_cnt >= FLUSH_START);
  assign line_on  = href_acc | fl_href;
  // Read one column ahead; idle lines park on address 0 so column 0 is ready at the first href.
  assign rd_addr  = (line_on && col != LAST_COL) ? col + AW'(1) : '0;

  vip_line_buffer #(.DEPTH(IMG_HDISP), .WIDTH(8)) u_lb1 (
    .clk     (clk),
    .wr_en   (href_acc),
    .wr_addr (col),
    .wr_data (per_img_gray),
    .rd_addr (rd_addr),
    .rd_data (lb1_q)
  );

  vip_line_buffer #(.DEPTH(IMG_HDISP), .WIDTH(8)) u_lb2 (
    .clk     (clk),
    .wr_en   (href_acc),
    .wr_addr (col),
    .wr_data (lb1_q),
    .rd_addr (rd_addr),
    .rd_data (lb2_q)
  );

  always_comb begin
    cur_col.top = (in_row == RW'(1)) ? (ZERO_PAD ? 8'h00 : lb1_q) : lb2_q;
    cur_col.mid = lb1_q;
    cur_col.bot = (state == ST_FLUSH) ? (ZERO_PAD ? 8'h00 : lb1_q) : per_img_gray;
    win_l = (oc == '0)       ? (ZERO_PAD ? ZERO_COL : col_d) : col_dd;
    win_r = (oc == LAST_COL) ? (ZERO_PAD ? ZERO_COL : col_d) : cur_col;
  end

  always_comb begin
    state_nxt = state;
    vs_set    = 1'b0;
    vs_clr    = 1'b0;
    case (state)
      ST_IDLE: if (per_img_vsync && !vsync_d) begin
        state_nxt = ST_FILL;
        vs_set    = 1'b1;
      end
      ST_FILL: begin
        if (eol) begin
          state_nxt = (IMG_VDISP == 1) ? ST_FLUSH : ST_STREAM;
        end else if (!per_img_vsync) begin
          state_nxt = ST_IDLE;
          vs_clr    = 1'b1;
        end
      end
      ST_STREAM: begin
        if (eol && in_row == LAST_ROW) state_nxt = ST_FLUSH;
        else if (!per_img_vsync && !href_acc_d) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (fl_done) state_nxt = ST_DONE;
      ST_DONE: if (done_cnt == 2'd2) begin
        state_nxt = ST_IDLE;
        vs_clr    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      vsync_d          <= 1'b1;
      href_acc_d       <= 1'b0;
      col              <= '0;
      oc               <= '0;
      in_row           <= '0;
      gap_cnt          <= '0;
      fl_done          <= 1'b0;
      done_cnt         <= '0;
      v_d              <= 1'b0;
      col_d            <= '0;
      col_dd           <= '0;
      matrix_img_vsync <= 1'b0;
      matrix_img_href  <= 1'b0;
      {matrix_p11, matrix_p12, matrix_p13} <= '0;
      {matrix_p21, matrix_p22, matrix_p23} <= '0;
      {matrix_p31, matrix_p32, matrix_p33} <= '0;
    end else begin
      state      <= state_nxt;
      vsync_d    <= per_img_vsync;
      href_acc_d <= href_acc;
      col        <= line_on ? col + AW'(1) : '0;
      oc         <= v_d ? oc + AW'(1) : '0;
      gap_cnt    <= href_acc ? '0 : ((gap_cnt != '1) ? gap_cnt + 16'd1 : gap_cnt);
      fl_done    <= (state == ST_FLUSH) & (fl_done | (fl_href & (col == LAST_COL)));
      done_cnt   <= (state == ST_DONE) ? done_cnt + 2'd1 : '0;
      if (state == ST_IDLE) in_row <= '0;
      else if (eol)         in_row <= in_row + RW'(1);
      // Output row r is produced while input row r+1 (or the flush line) streams.
      v_d    <= line_on & (in_row != '0);
      col_d  <= cur_col;
      col_dd <= col_d;
      if (vs_set)      matrix_img_vsync <= 1'b1;
      else if (vs_clr) matrix_img_vsync <= 1'b0;
      matrix_img_href <= v_d;
      if (v_d) begin
        {matrix_p11, matrix_p12, matrix_p13} <= {win_l.top, col_d.top, win_r.top};
        {matrix_p21, matrix_p22, matrix_p23} <= {win_l.mid, col_d.mid, win_r.mid};
        {matrix_p31, matrix_p32, matrix_p33} <= {win_l.bot, col_d.bot, win_r.bot};
      end
    end
  end

endmodule

// File: tb/tb_vip_matrix_generate_3x3.sv
// Self-checking bench for vip_matrix_generate_3x3 on a 4x3 image with a reference window model.
module tb_vip_matrix_generate_3x3;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_img_vsync = 1'b0;
  logic       per_img_href = 1'b0;
  logic [7:0] per_img_gray = 8'h00;
  logic       matrix_img_vsync, matrix_img_href;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  vip_matrix_generate_3x3 #(.IMG_HDISP(H), .IMG_VDISP(V), .FLUSH_GAP(GAP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_img_vsync    (per_img_vsync),
    .per_img_href     (per_img_href),
    .per_img_gray     (per_img_gray),
    .matrix_img_vsync (matrix_img_vsync),
    .matrix_img_href  (matrix_img_href),
    .matrix_p11       (matrix_p11),
    .matrix_p12       (matrix_p12),
    .matrix_p13       (matrix_p13),
    .matrix_p21       (matrix_p21),
    .matrix_p22       (matrix_p22),
    .matrix_p23       (matrix_p23),
    .matrix_p31       (matrix_p31),
    .matrix_p32       (matrix_p32),
    .matrix_p33       (matrix_p33)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [V][H];
  logic [71:0] expq [$];
  logic [71:0] held = '0;
  int exp_first_out = -1000, exp_flush_out = -1000, exp_vs_rise = -1000;
  int exp_k = 0, lines_out = 0, last_href_cyc = -1000, run = 0;
  bit prev_href = 1'b0, prev_vs = 1'b0;

  logic [71:0] dut_win;
  assign dut_win = {matrix_p11, matrix_p12, matrix_p13,
                    matrix_p21, matrix_p22, matrix_p23,
                    matrix_p31, matrix_p32, matrix_p33};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pixel of a k-line frame at (r,c); out-of-image neighbours replicate the edge or read zero.
  function automatic logic [7:0] px(input int r, input int c, input int k);
    int rr, cc;
`ifdef VIP_MATRIX_ZERO_PAD_EN
    if (r < 0 || r >= k || c < 0 || c >= H) return 8'h00;
`endif
    rr = (r < 0) ? 0 : ((r > k - 1) ? k - 1 : r);
    cc = (c < 0) ? 0 : ((c > H - 1) ? H - 1 : c);
    return img[rr][cc];
  endfunction

  function automatic logic [71:0] win(input int r, input int c, input int k);
    logic [71:0] w = '0;
    for (int i = -1; i <= 1; i++)
      for (int j = -1; j <= 1; j++)
        w = (w << 8) | 72'(px(r + i, c + j, k));
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_href = 1'b0;
      prev_vs   = 1'b0;
      held      = '0;
      run       = 0;
    end else begin
      if (matrix_img_href) begin
        if (!prev_href) begin
          lines_out++;
          run = 0;
          if (lines_out == exp_k)  chk("flush_line_start", 72'(cyc), 72'(exp_flush_out));
          else if (lines_out == 1) chk("first_line_start", 72'(cyc), 72'(exp_first_out));
        end
        run++;
        last_href_cyc = cyc;
        if (expq.size() == 0) begin
          chk("unexpected_href", 72'(matrix_img_href), 72'(0));
        end else begin
          held = expq.pop_front();
          chk("window", dut_win, held);
        end
      end else begin
        if (prev_href) chk("line_length", 72'(run), 72'(H));
        chk("hold", dut_win, held);
      end
      if (matrix_img_vsync && !prev_vs)
        chk("vsync_rise_cycle", 72'(cyc), 72'(exp_vs_rise));
      if (!matrix_img_vsync && prev_vs)
        chk("vsync_fall_cycle", 72'(cyc), 72'(last_href_cyc + 3));
      prev_href = matrix_img_href;
      prev_vs   = matrix_img_vsync;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input bit pattern);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = pattern ? 8'(16 * r + c) : 8'($urandom);
  endtask

  task automatic drive_line(input int l);
    for (int c = 0; c < H; c++) begin
      if (l == 1 && c == 0) exp_first_out = cyc + 2;
      per_img_href = 1'b1;
      per_img_gray = (l < V) ? img[l][c] : 8'($urandom);
      tick();
    end
    per_img_href = 1'b0;
    per_img_gray = 8'($urandom);
    if (l == exp_k - 1) exp_flush_out = cyc + GAP;
  endtask

  task automatic wait_frame_end(input string name);
    for (int i = 0; i < 400 && matrix_img_vsync; i++) tick();
    chk(name, 72'(matrix_img_vsync), 72'(0));
  endtask

  task automatic drive_frame(input int n, input bit pattern);
    int k;
    k = (n < V) ? n : V;
    fill_img(pattern);
    exp_k = k;
    lines_out = 0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < H; c++)
        expq.push_back(win(r, c, k));
    per_img_vsync = 1'b1;
    exp_vs_rise = cyc + 1;
    repeat (3) tick();
    for (int l = 0; l < n; l++) begin
      drive_line(l);
      if (l == n - 1 && n < V) per_img_vsync = 1'b0;
      else repeat ($urandom_range(5, 9)) tick();
    end
    if (n >= V) begin
      repeat ($urandom_range(0, 25)) tick();
      per_img_vsync = 1'b0;
    end
    wait_frame_end("frame_end_vsync");
    chk("lines_per_frame", 72'(lines_out), 72'(k));
    chk("windows_left", 72'(expq.size()), 72'(0));
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_vsync"}, 72'(matrix_img_vsync), 72'(0));
    chk({tag, "_href"}, 72'(matrix_img_href), 72'(0));
    chk({tag, "_window"}, dut_win, 72'(0));
  endtask

  task automatic abort_frame;
    fill_img(1'b0);
    exp_k = V;
    lines_out = 0;
    for (int c = 0; c < H; c++) expq.push_back(win(0, c, V));
    per_img_vsync = 1'b1;
    exp_vs_rise = cyc + 1;
    repeat (3) tick();
    drive_line(0);
    repeat (6) tick();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) exp_first_out = cyc + 2;
      per_img_href = 1'b1;
      per_img_gray = img[1][c];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    expq.delete();
    exp_vs_rise = -1000;
    lines_out = 0;
    per_img_gray = img[1][2];
    tick();
    rst_n = 1'b1;
    per_img_gray = img[1][3];
    tick();
    per_img_href = 1'b0;
    repeat (6) tick();
    drive_line(2);
    repeat (6) tick();
    per_img_vsync = 1'b0;
    repeat (12) tick();
    chk("aborted_frame_lines", 72'(lines_out), 72'(0));
    chk("aborted_frame_vsync", 72'(matrix_img_vsync), 72'(0));
  endtask

  initial begin
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_outputs_zero("post_reset_idle");

    fill_img(1'b1);
`ifdef VIP_MATRIX_ZERO_PAD_EN
    chk("model_zp_00", win(0, 0, 3), 72'h00_00_00_00_00_01_00_10_11);
`else
    chk("model_rep_00", win(0, 0, 3), 72'h00_00_01_00_00_01_10_10_11);
    chk("model_rep_23", win(2, 3, 3), 72'h12_13_13_22_23_23_22_23_23);
`endif

    drive_frame(3, 1'b1);
    drive_frame(3, 1'b0);
    drive_frame(4, 1'b0);
    drive_frame(2, 1'b0);
    drive_frame(1, 1'b0);
    abort_frame();
    drive_frame(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
